// File: rtl/instr_encoder_loader.sv
// Builds 32-bit MIPS-lite instruction words from symbolic requests and writes
// them sequentially into instruction memory over a write/ack handshake.
module instr_encoder_loader #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 256,
    localparam int               CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  word_count,
    output logic              full,
    output logic              err_invalid
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [3:0] OP_RTYPE  = 4'd0;
    localparam logic [3:0] OP_LW     = 4'd1;
    localparam logic [3:0] OP_SW     = 4'd2;
    localparam logic [3:0] OP_BEQ    = 4'd3;
    localparam logic [3:0] OP_J      = 4'd4;
    localparam logic [3:0] OP_ORI    = 4'd5;
    localparam logic [3:0] OP_BLTZAL = 4'd6;
    localparam logic [3:0] OP_JSPAL  = 4'd7;
    localparam logic [3:0] OP_BALN   = 4'd8;

    localparam logic [5:0] OPC_LW     = 6'd35;
    localparam logic [5:0] OPC_SW     = 6'd43;
    localparam logic [5:0] OPC_BEQ    = 6'd4;
    localparam logic [5:0] OPC_J      = 6'd2;
    localparam logic [5:0] OPC_ORI    = 6'd13;
    localparam logic [5:0] OPC_BLTZAL = 6'd34;
    localparam logic [5:0] OPC_JSPAL  = 6'd19;
    localparam logic [5:0] OPC_BALN   = 6'd27;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [1:0]        state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [31:0]       wdata_q,  wdata_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              err_q,    err_d;

    logic              enc_valid;
    logic [31:0]       enc_word;
    logic [CNT_W-1:0]  count_inc;

    always_comb begin
        enc_valid = 1'b1;
        enc_word  = '0;
        case (op_sel)
            OP_RTYPE:  enc_word = {6'd0, rs, rt, rd, 5'd0, funct};
            OP_LW:     enc_word = {OPC_LW, rs, rt, imm};
            OP_SW:     enc_word = {OPC_SW, rs, rt, imm};
            OP_BEQ:    enc_word = {OPC_BEQ, rs, rt, imm};
            OP_ORI:    enc_word = {OPC_ORI, rs, rt, imm};
            OP_BLTZAL: enc_word = {OPC_BLTZAL, rs, rt, imm};
            OP_JSPAL:  enc_word = {OPC_JSPAL, rs, rt, imm};
            OP_J:      enc_word = {OPC_J, target};
            OP_BALN:   enc_word = {OPC_BALN, target};
            default:   enc_valid = 1'b0;
        endcase
    end

    assign count_inc = count_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        // restart dominates everything, including an ack landing in the same cycle
        if (restart) begin
            state_d = ST_IDLE;
            addr_d  = BASE_ADDR;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (enc_valid) begin
                            wdata_d = enc_word;
                            state_d = ST_WRITE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ack) begin
                        count_d = count_inc;
                        addr_d  = addr_q + ADDR_W'(4);
                        state_d = (count_inc == DEPTH_C) ? ST_FULL : ST_IDLE;
                    end
                end
                ST_FULL: state_d = ST_FULL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign mem_we      = (state_q == ST_WRITE);
    assign full        = (count_q == DEPTH_C);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign word_count  = count_q;
    assign err_invalid = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: directed encoding table, randomized traffic against an
// arithmetic reference model, and hand sequences for full/restart/reset cases.
module tb_instr_encoder_loader;

    localparam logic [31:0] BASE_A = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  op_sel = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;

    logic        restart_a = 0, in_valid_a = 0, mem_ack_a = 0;
    logic        in_ready_a, mem_we_a, full_a, err_a;
    logic [31:0] mem_addr_a, mem_wdata_a;
    logic [8:0]  word_count_a;

    logic        restart_b = 0, in_valid_b = 0, mem_ack_b = 0;
    logic        in_ready_b, mem_we_b, full_b, err_b;
    logic [15:0] mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [1:0]  word_count_b;

    instr_encoder_loader #(.ADDR_W(32), .BASE_ADDR(BASE_A), .DEPTH(256)) dut_a (
        .clk(clk), .rst_n(rst_n), .restart(restart_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd),
        .funct(funct), .imm(imm), .target(target), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_ack(mem_ack_a),
        .word_count(word_count_a), .full(full_a), .err_invalid(err_a)
    );

    instr_encoder_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000), .DEPTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .restart(restart_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd),
        .funct(funct), .imm(imm), .target(target), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_ack(mem_ack_b),
        .word_count(word_count_b), .full(full_b), .err_invalid(err_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_count_a = 0;
    logic exp_err_a = 1'b0;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic [31:0] exp_word;
        int          hold;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference encoder: opcode table indexed by op_sel, fields placed arithmetically.
    function automatic logic [32:0] model_encode(input logic [3:0] op, input logic [4:0] f_rs,
            input logic [4:0] f_rt, input logic [4:0] f_rd, input logic [5:0] f_funct,
            input logic [15:0] f_imm, input logic [25:0] f_target);
        int opc [9] = '{0, 35, 43, 4, 2, 13, 34, 19, 27};
        longint w;
        int idx;
        if (op > 4'd8) return 33'h0;
        idx = int'(op);
        w = longint'(opc[idx]) * 64'd67108864;
        if (idx == 0)
            w = w + f_rs * 2097152 + f_rt * 65536 + f_rd * 2048 + f_funct;
        else if (idx == 4 || idx == 8)
            w = w + f_target;
        else
            w = w + f_rs * 2097152 + f_rt * 65536 + f_imm;
        return {1'b1, w[31:0]};
    endfunction

    task automatic set_fields(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b,
            input logic [4:0] c, input logic [5:0] f, input logic [15:0] i, input logic [25:0] t);
        op_sel = op; rs = a; rt = b; rd = c; funct = f; imm = i; target = t;
    endtask

    // One request on DUT A, checked against the expected word; hold = cycles with ack low.
    task automatic txn_a(input string name, input logic exp_valid, input logic [31:0] exp_word,
            input int hold);
        logic [31:0] exp_addr;
        exp_addr = BASE_A + 32'(4 * exp_count_a);
        chk({name, ".ready"}, in_ready_a, 1'b1);
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        if (!exp_valid) begin
            exp_err_a = 1'b1;
            chk({name, ".we_inv"}, mem_we_a, 1'b0);
            chk({name, ".err"}, err_a, 1'b1);
            chk({name, ".cnt_inv"}, word_count_a, 9'(exp_count_a));
            chk({name, ".ready_inv"}, in_ready_a, 1'b1);
            $display("txn %s op=%0d invalid, err=%0b", name, op_sel, err_a);
            return;
        end
        chk({name, ".we"}, mem_we_a, 1'b1);
        chk({name, ".wdata"}, mem_wdata_a, exp_word);
        chk({name, ".addr"}, mem_addr_a, exp_addr);
        chk({name, ".busy"}, in_ready_a, 1'b0);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({name, ".hold_we"}, mem_we_a, 1'b1);
            chk({name, ".hold_wdata"}, mem_wdata_a, exp_word);
            chk({name, ".hold_addr"}, mem_addr_a, exp_addr);
            chk({name, ".hold_busy"}, in_ready_a, 1'b0);
        end
        mem_ack_a = 1'b1;
        tick();
        mem_ack_a = 1'b0;
        exp_count_a++;
        chk({name, ".cnt"}, word_count_a, 9'(exp_count_a));
        chk({name, ".addr_next"}, mem_addr_a, BASE_A + 32'(4 * exp_count_a));
        chk({name, ".idle"}, in_ready_a, 1'b1);
        chk({name, ".we_off"}, mem_we_a, 1'b0);
        chk({name, ".err_keep"}, err_a, exp_err_a);
        $display("txn %s op=%0d word=0x%08h addr=0x%0h hold=%0d", name, op_sel, mem_wdata_a,
                 exp_addr, hold);
    endtask

    task automatic pulse_b();
        in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
    endtask

    task automatic ack_b();
        mem_ack_b = 1'b1;
        tick();
        mem_ack_b = 1'b0;
    endtask

    initial begin
        logic [32:0] m;
        vecs[0] = '{4'd0, 5'd1,  5'd2, 5'd3, 6'h20, 16'h0000, 26'h0,      32'h00221820, 0};
        vecs[1] = '{4'd1, 5'd29, 5'd8, 5'd0, 6'h00, 16'h0004, 26'h0,      32'h8FA80004, 1};
        vecs[2] = '{4'd5, 5'd0,  5'd9, 5'd0, 6'h00, 16'h00FF, 26'h0,      32'h340900FF, 0};
        vecs[3] = '{4'd6, 5'd4,  5'd0, 5'd0, 6'h00, 16'hFFFE, 26'h0,      32'h8880FFFE, 2};
        vecs[4] = '{4'd7, 5'd5,  5'd0, 5'd0, 6'h00, 16'h0010, 26'h0,      32'h4CA00010, 0};
        vecs[5] = '{4'd4, 5'd0,  5'd0, 5'd0, 6'h00, 16'h0000, 26'h40,     32'h08000040, 5};
        vecs[6] = '{4'd8, 5'd0,  5'd0, 5'd0, 6'h00, 16'h0000, 26'h100,    32'h6C000100, 5};
        vecs[7] = '{4'd2, 5'd2,  5'd3, 5'd0, 6'h00, 16'h0008, 26'h0,      32'hAC430008, 1};
        vecs[8] = '{4'd3, 5'd1,  5'd2, 5'd0, 6'h00, 16'hFFFF, 26'h0,      32'h1022FFFF, 0};

        // Reset values
        #12;
        chk("rst.ready", in_ready_a, 1'b1);
        chk("rst.we", mem_we_a, 1'b0);
        chk("rst.addr", mem_addr_a, BASE_A);
        chk("rst.wdata", mem_wdata_a, 32'h0);
        chk("rst.cnt", word_count_a, 9'd0);
        chk("rst.full", full_a, 1'b0);
        chk("rst.err", err_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst.ready_after", in_ready_a, 1'b1);

        // Directed encoding table
        for (int v = 0; v < 9; v++) begin
            set_fields(vecs[v].op, vecs[v].rs, vecs[v].rt, vecs[v].rd, vecs[v].funct,
                       vecs[v].imm, vecs[v].target);
            txn_a($sformatf("vec%0d", v), 1'b1, vecs[v].exp_word, vecs[v].hold);
        end

        // Invalid op, then a valid op lands at the unchanged address
        set_fields(4'd12, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1, 26'h1);
        txn_a("inv12", 1'b0, 32'h0, 0);
        set_fields(4'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h3FFFFFF);
        txn_a("after_inv", 1'b1, 32'h0BFFFFFF, 0);

        // Randomized traffic against the model
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                mem_ack_a = 1'b1;
                tick();
                mem_ack_a = 1'b0;
                chk("idle_ack.cnt", word_count_a, 9'(exp_count_a));
            end
            set_fields(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
                       6'($urandom), 16'($urandom), 26'($urandom));
            m = model_encode(op_sel, rs, rt, rd, funct, imm, target);
            txn_a($sformatf("rnd%0d", r), m[32], m[31:0], int'($urandom_range(0, 3)));
        end

        // DEPTH=2 instance: invalid op, fill, ignore while full, restart
        set_fields(4'd9, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0);
        pulse_b();
        chk("b.inv_err", err_b, 1'b1);
        chk("b.inv_we", mem_we_b, 1'b0);
        set_fields(4'd1, 5'd29, 5'd8, 5'd0, 6'd0, 16'h0004, 26'h0);
        pulse_b();
        chk("b.w1_we", mem_we_b, 1'b1);
        chk("b.w1_addr", mem_addr_b, 16'h0000);
        ack_b();
        chk("b.w1_cnt", word_count_b, 2'd1);
        chk("b.w1_full", full_b, 1'b0);
        pulse_b();
        chk("b.w2_addr", mem_addr_b, 16'h0004);
        chk("b.w2_wdata", mem_wdata_b, 32'h8FA80004);
        ack_b();
        chk("b.full", full_b, 1'b1);
        chk("b.full_cnt", word_count_b, 2'd2);
        chk("b.full_ready", in_ready_b, 1'b0);
        chk("b.full_we", mem_we_b, 1'b0);
        pulse_b();
        ack_b();
        chk("b.full_ignore_we", mem_we_b, 1'b0);
        chk("b.full_ignore_cnt", word_count_b, 2'd2);
        chk("b.full_hold", full_b, 1'b1);
        restart_b = 1'b1;
        tick();
        restart_b = 1'b0;
        chk("b.rs_full", full_b, 1'b0);
        chk("b.rs_cnt", word_count_b, 2'd0);
        chk("b.rs_addr", mem_addr_b, 16'h0000);
        chk("b.rs_err", err_b, 1'b0);
        chk("b.rs_ready", in_ready_b, 1'b1);
        $display("txn b_fill_restart done");

        // restart coincident with ack while writing
        pulse_b();
        chk("b.rw_we", mem_we_b, 1'b1);
        restart_b = 1'b1;
        mem_ack_b = 1'b1;
        tick();
        restart_b = 1'b0;
        mem_ack_b = 1'b0;
        chk("b.rw_cnt", word_count_b, 2'd0);
        chk("b.rw_we_off", mem_we_b, 1'b0);
        chk("b.rw_addr", mem_addr_b, 16'h0000);
        chk("b.rw_ready", in_ready_b, 1'b1);
        $display("txn b_restart_in_write done");

        // Async reset mid-WRITE on A (err set first so clearing is observable)
        set_fields(4'd15, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0);
        in_valid_a = 1'b1;
        tick();
        set_fields(4'd5, 5'd3, 5'd3, 5'd0, 6'd0, 16'h1234, 26'h0);
        tick();
        in_valid_a = 1'b0;
        chk("ar.we_before", mem_we_a, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.we", mem_we_a, 1'b0);
        chk("ar.addr", mem_addr_a, BASE_A);
        chk("ar.wdata", mem_wdata_a, 32'h0);
        chk("ar.cnt", word_count_a, 9'd0);
        chk("ar.err", err_a, 1'b0);
        chk("ar.full", full_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar.ready", in_ready_a, 1'b1);
        $display("txn async_reset_mid_write done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the opcode decoder: takes a symbolic instruction (operation select plus register/immediate fields) and builds the 32-bit MIPS-lite instruction word.
- Opcodes are identical to the control decoder's: R-type 0, lw 35, sw 43, beq 4, j 2, ori 13, bltzal 34, jspal 19, baln 27.
- Writes encoded words sequentially into instruction memory through a write/ack handshake.
- Used by the testbench/boot path to preload programs.

Parameters:
- ADDR_W, 32, width of the byte address driven to instruction memory.
- BASE_ADDR, 0, byte address of the first word written.
- DEPTH, 256, maximum words written before the block reports full; 1..2^(ADDR_W-2).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- restart  input  1  synchronous; clears address/count, aborts any pending write.
- in_valid  input  1  instruction request valid.
- in_ready  output  1  block can accept a request.
- op_sel  input  4  0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 J, 5 ORI, 6 BLTZAL, 7 JSPAL, 8 BALN; 9-15 invalid.
- rs, rt, rd  input  5 each  register fields.
- funct  input  6  R-type function field.
- imm  input  16  immediate/offset.
- target  input  26  jump target.
- mem_we  output  1  write request to instruction memory.
- mem_addr  output  ADDR_W  byte address of the write.
- mem_wdata  output  32  encoded instruction.
- mem_ack  input  1  memory accepted the write this cycle.
- word_count  output  clog2(DEPTH+1)  words successfully written.
- full  output  1  word_count == DEPTH.
- err_invalid  output  1  sticky; an invalid op_sel was accepted.

Behaviour:
- Encoding is combinational from the request fields, registered on accept:
  - RTYPE: {6'd0, rs, rt, rd, 5'd0, funct}.
  - LW/SW/BEQ/ORI/BLTZAL/JSPAL: {opcode, rs, rt, imm}.
  - J/BALN: {opcode, target}.
- FSM states:
  - IDLE: in_ready=1.
    - in_valid with a valid op: latch mem_wdata, go to WRITE.
    - in_valid with an invalid op: accept, set err_invalid, write nothing, stay in IDLE.
  - WRITE: in_ready=0, mem_we=1. mem_wdata and mem_addr are held stable until mem_ack.
    - On mem_ack: word_count+1, mem_addr+4; go to FULL if the new count equals DEPTH, else IDLE.
    - mem_ack outside WRITE is ignored.
  - FULL: in_ready=0, mem_we=0, full=1. Exits only on restart or reset.
- Latency: accept at edge N puts mem_we=1 from cycle N+1. Minimum 2 cycles per instruction; in_ready is never high in WRITE.
- restart has priority over all other events in every state:
  - Next state IDLE, mem_addr=BASE_ADDR, word_count=0, mem_we=0.
  - An in-flight write is abandoned and a coincident mem_ack is ignored.
  - err_invalid is also cleared.
- Reset (async, any state):
  - state IDLE, in_ready=1 once rst_n is high.
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0, full=0, err_invalid=0.
- mem_addr wraps modulo 2^ADDR_W; no overflow flag (DEPTH bounds it in normal use).
- DEPTH=1: the first acked write goes directly to FULL.

Test Plan:
- Reset, then RTYPE rs=1 rt=2 rd=3 funct=0x20 → mem_we next cycle, mem_wdata=0x00221820, mem_addr=BASE_ADDR; ack → word_count=1, mem_addr=BASE_ADDR+4, in_ready=1.
- LW rs=29 rt=8 imm=0x0004 → 0x8FA80004; ORI rs=0 rt=9 imm=0x00FF → 0x340900FF; BLTZAL rs=4 rt=0 imm=0xFFFE → 0x8880FFFE; JSPAL rs=5 rt=0 imm=0x0010 → 0x4CA00010.
- J target=0x0000040 → 0x08000040; BALN target=0x0000100 → 0x6C000100. Hold mem_ack low 5 cycles: mem_we, mem_wdata and mem_addr stable and in_ready=0 throughout.
- op_sel=12 with in_valid → no mem_we, err_invalid=1, word_count unchanged. A following valid op still writes at the unchanged address.
- DEPTH=2: two acked writes → full=1, in_ready=0, further in_valid ignored. restart → full=0, word_count=0, mem_addr=BASE_ADDR, err_invalid=0.
- restart asserted in WRITE with a coincident mem_ack → word_count unchanged (0), mem_we=0 next cycle. Also: rst_n low mid-WRITE → all outputs at reset values immediately.
